// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified memory arbiter.
package unified_mem_arbiter_pkg;

  localparam logic [2:0] F3_LW = 3'b010;

  typedef enum logic [1:0] {
    ARB_RUN    = 2'd0,
    ARB_DRAIN  = 2'd1,
    ARB_HALTED = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/unified_mem_arbiter_starve.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
module arb_starve_counter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MAX_DATA_RUN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [3:0] LIMIT = 4'(MAX_DATA_RUN);

  logic [3:0] cnt_q, cnt_d;

  // Clear wins over increment; the count parks at LIMIT and never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (inc_i && (cnt_q < LIMIT)) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter: data over fetch, with a starvation escape for fetch,
// and a halt path that drains the outstanding read before parking.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int MAX_DATA_RUN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              halted
);

  arb_state_e state_q, state_d;
  logic       pend_q, pend_d;
  owner_e     owner_q, owner_d;
  logic       halted_q;
  logic       at_limit;
  logic       grant_ok, dm_win, if_win;

  assign grant_ok = (state_q == ARB_RUN) && !halt;
  assign dm_win   = grant_ok && dm_req && !(if_req && at_limit);
  assign if_win   = grant_ok && if_req && !dm_win;
  assign if_gnt   = if_win;
  assign dm_gnt   = dm_win;

  arb_starve_counter #(
    .MAX_DATA_RUN (MAX_DATA_RUN)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (dm_win && if_req),
    .clr_i      (if_win || !if_req),
    .at_limit_o (at_limit)
  );

  // Memory port follows the winner; idle cycles present an all-zero request.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_size  = 3'd0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = 32'd0;
    if (dm_win) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_size  = dm_size;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_win) begin
      mem_en   = 1'b1;
      mem_size = F3_LW;
      mem_addr = if_addr;
    end else begin
      mem_en = 1'b0;
    end
  end

  assign pend_d  = if_win || (dm_win && !dm_we);
  assign owner_d = dm_win ? OWN_DM : OWN_IF;

  // A response returning in the halt cycle is delivered there, so only a read
  // issued in that cycle could need DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_RUN: begin
        if (halt) begin
          state_d = pend_d ? ARB_DRAIN : ARB_HALTED;
        end else begin
          state_d = ARB_RUN;
        end
      end
      ARB_DRAIN:  state_d = ARB_HALTED;
      ARB_HALTED: state_d = ARB_HALTED;
      default:    state_d = ARB_HALTED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_RUN;
      pend_q   <= 1'b0;
      owner_q  <= OWN_IF;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      owner_q  <= owner_d;
      halted_q <= (state_d == ARB_HALTED);
    end
  end

  assign if_rvalid = pend_q && (owner_q == OWN_IF);
  assign dm_rvalid = pend_q && (owner_q == OWN_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : 32'd0;
  assign halted    = halted_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed table, randomized reference-model run and halt/reset sequences for unified_mem_arbiter.
module tb_unified_mem_arbiter;

  localparam int MAX_RUN = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        if_req, dm_req, dm_we;
  logic [11:0] if_addr, dm_addr, mem_addr;
  logic [2:0]  dm_size, mem_size;
  logic [31:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, halted;
  logic        mem_init;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        halt;
    logic        if_req;
    logic [11:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [11:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        e_if_gnt;
    logic        e_dm_gnt;
    logic        e_if_rv;
    logic        e_dm_rv;
    logic [31:0] e_rdata;
    logic        e_halted;
  } vec_t;

  vec_t tbl [15];

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(12), .MAX_DATA_RUN(MAX_RUN)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halted(halted)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  // Word-wide memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[11:2]];
    end
  end

  function automatic vec_t mk(input logic h, input logic ir, input logic [11:0] ia,
                              input logic dr, input logic dw, input logic [11:0] da,
                              input logic [31:0] dd, input logic eig, input logic edg,
                              input logic eir, input logic edr, input logic [31:0] erd,
                              input logic eh);
    vec_t v;
    v.halt = h; v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw;
    v.dm_addr = da; v.dm_wdata = dd; v.e_if_gnt = eig; v.e_dm_gnt = edg;
    v.e_if_rv = eir; v.e_dm_rv = edr; v.e_rdata = erd; v.e_halted = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %0s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle(input logic eif, input logic edm, input logic eifrv,
                             input logic edmrv, input logic [31:0] erd, input logic eh);
    chk("if_gnt", 32'(if_gnt), 32'(eif));
    chk("dm_gnt", 32'(dm_gnt), 32'(edm));
    chk("mem_en", 32'(mem_en), 32'(eif | edm));
    if (edm) begin
      chk("mem_we_dm", 32'(mem_we), 32'(dm_we));
      chk("mem_addr_dm", 32'(mem_addr), 32'(dm_addr));
      chk("mem_size_dm", 32'(mem_size), 32'(dm_size));
      if (dm_we) chk("mem_wdata", mem_wdata, dm_wdata);
    end else if (eif) begin
      chk("mem_we_if", 32'(mem_we), 32'd0);
      chk("mem_addr_if", 32'(mem_addr), 32'(if_addr));
      chk("mem_size_if", 32'(mem_size), 32'd2);
    end
    chk("if_rvalid", 32'(if_rvalid), 32'(eifrv));
    chk("dm_rvalid", 32'(dm_rvalid), 32'(edmrv));
    chk("if_rdata", if_rdata, eifrv ? erd : 32'd0);
    chk("dm_rdata", dm_rdata, edmrv ? erd : 32'd0);
    chk("halted", 32'(halted), 32'(eh));
  endtask

  task automatic check_reset_vals();
    check_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_size", 32'(mem_size), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    halt = v.halt; if_req = v.if_req; if_addr = v.if_addr;
    dm_req = v.dm_req; dm_we = v.dm_we; dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
    dm_size = 3'b010;
    @(negedge clk);
    check_cycle(v.e_if_gnt, v.e_dm_gnt, v.e_if_rv, v.e_dm_rv, v.e_rdata, v.e_halted);
  endtask

  task automatic clear_inputs();
    halt = 1'b0; if_req = 1'b0; if_addr = 12'd0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = 12'd0; dm_wdata = 32'd0; dm_size = 3'd0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int          run;
    logic        p_if_rv, p_dm_rv, if_hold, dm_hold, e_if, e_dm;
    logic [31:0] p_rd;

    rst = 1'b1;
    mem_init = 1'b1;
    clear_inputs();
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    mem_init = 1'b0;
    rst = 1'b0;

    // IF stream, store/load, then both held high to exercise the starvation escape.
    tbl[0]  = mk(1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 12'h004, 1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, init_word(0), 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 12'h008, 1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, init_word(1), 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h100, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, init_word(2), 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h100, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    tbl[6]  = mk(1'b0, 1'b1, 12'h00C, 1'b1, 1'b0, 12'h100, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b1, 12'h00C, 1'b1, 1'b0, 12'h100, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 12'h00C, 1'b1, 1'b0, 12'h100, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 12'h00C, 1'b1, 1'b0, 12'h100, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, 12'h00C, 1'b1, 1'b0, 12'h100, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, init_word(3), 1'b0);
    tbl[11] = mk(1'b0, 1'b1, 12'h00C, 1'b1, 1'b0, 12'h100, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    tbl[12] = mk(1'b0, 1'b1, 12'h00C, 1'b1, 1'b0, 12'h100, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    tbl[13] = mk(1'b0, 1'b1, 12'h00C, 1'b1, 1'b0, 12'h100, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, init_word(3), 1'b0);
    for (int i = 0; i < 15; i++) run_vec(tbl[i]);

    // Random traffic; stores stay above 0x200 so the directed words remain intact.
    ref_mem[64] = 32'hDEADBEEF;
    run = 0; p_if_rv = 1'b0; p_dm_rv = 1'b0; p_rd = 32'd0; if_hold = 1'b0; dm_hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (!if_hold) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = {10'($urandom_range(0, 1023)), 2'b00};
      end
      if (!dm_hold) begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_we    = $urandom_range(0, 1) == 1;
        dm_addr  = {10'($urandom_range(128, 1023)), 2'b00};
        dm_wdata = $urandom;
        dm_size  = 3'($urandom_range(0, 7));
      end
      e_dm = dm_req && !(if_req && (run == MAX_RUN));
      e_if = if_req && !e_dm;
      @(negedge clk);
      check_cycle(e_if, e_dm, p_if_rv, p_dm_rv, p_rd, 1'b0);
      p_if_rv = e_if;
      p_dm_rv = e_dm && !dm_we;
      if (e_if) p_rd = ref_mem[if_addr[11:2]];
      else if (e_dm && !dm_we) p_rd = ref_mem[dm_addr[11:2]];
      else p_rd = 32'd0;
      if (e_dm && dm_we) ref_mem[dm_addr[11:2]] = dm_wdata;
      if (e_if || !if_req) run = 0;
      else if (e_dm && run < MAX_RUN) run++;
      if_hold = if_req && !e_if;
      dm_hold = dm_req && !e_dm;
    end

    // Halt one cycle after a load grant: response delivered, then parked for good.
    do_reset();
    run_vec(mk(1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h100, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0));
    run_vec(mk(1'b1, 1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0));
    for (int i = 0; i < 3; i++)
      run_vec(mk(1'b0, 1'b1, 12'h010, 1'b1, 1'b0, 12'h100, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1));

    // Halt while idle with both requesting.
    do_reset();
    run_vec(mk(1'b1, 1'b1, 12'h010, 1'b1, 1'b0, 12'h100, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
    run_vec(mk(1'b0, 1'b1, 12'h010, 1'b1, 1'b0, 12'h100, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1));
    run_vec(mk(1'b0, 1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1));

    // Reset in the cycle after a fetch grant discards the response.
    do_reset();
    run_vec(mk(1'b0, 1'b1, 12'h004, 1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    run_vec(mk(1'b0, 1'b1, 12'h008, 1'b0, 1'b0, 12'h000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
    run_vec(mk(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, init_word(2), 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
